// File: rtl/jtag_uart_tx_feeder.sv
// Byte-stream to JTAG UART Avalon-MM master: FIFO-buffers bytes and writes them only while UART credit remains.
// Latency: byte into empty FIFO with credit and no stall -> write strobe 2 cycles later; credit refreshed by polling WSPACE.
// Backpressure: in_ready drops only when the FIFO is full (registered level); Avalon commands hold while waitrequest=1.
module jtag_uart_tx_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int POLL_GAP   = 64
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        avm_chipselect,
  output logic                        avm_address,
  output logic                        avm_read_n,
  input  logic [31:0]                 avm_readdata,
  output logic                        avm_write_n,
  output logic [31:0]                 avm_writedata,
  input  logic                        avm_waitrequest,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POLL  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_credit;
  logic [GW-1:0] r_gap;
  logic          r_cs;
  logic          r_addr;
  logic          r_read_n;
  logic          r_write_n;
  logic [31:0]   r_wdata;

  logic          w_push;
  logic          w_pop;
  logic          w_done;
  logic [15:0]   w_wspace;
  logic          w_unused_rd;

  // A command completes on the first cycle it is presented without a stall.
  assign w_done   = r_cs & ~avm_waitrequest;
  // Full test uses the registered level only, so a same-cycle pop never opens a slot at full.
  assign in_ready = ~reset_reset & (r_level != LEVEL_FULL);
  assign w_push   = in_valid & in_ready;
  assign w_pop    = (r_state == S_WRITE) & w_done;
  assign w_wspace = avm_readdata[31:16];
  // Low half of the control register (interrupt enables etc.) is irrelevant here.
  assign w_unused_rd = ^avm_readdata[15:0];

  assign avm_chipselect = r_cs;
  assign avm_address    = r_addr;
  assign avm_read_n     = r_read_n;
  assign avm_write_n    = r_write_n;
  assign avm_writedata  = r_wdata;
  assign fifo_level     = r_level;
  assign busy           = (r_level != '0) | r_cs;

  // FIFO storage: payload needs no reset, validity is tracked by the pointers.
  always_ff @(posedge clk_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Control FSM with registered Avalon command; command fields only change on completion.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state   <= S_IDLE;
      r_cs      <= 1'b0;
      r_addr    <= 1'b0;
      r_read_n  <= 1'b1;
      r_write_n <= 1'b1;
      r_wdata   <= '0;
      r_credit  <= '0;
      r_gap     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_level != '0) begin
            r_cs <= 1'b1;
            if (r_credit != '0) begin
              r_state   <= S_WRITE;
              r_addr    <= 1'b0;
              r_write_n <= 1'b0;
              r_wdata   <= {24'h0, r_mem[r_rd_ptr]};
            end else begin
              r_state  <= S_POLL;
              r_addr   <= 1'b1;
              r_read_n <= 1'b0;
            end
          end
        end
        S_POLL: begin
          if (w_done) begin
            r_cs     <= 1'b0;
            r_read_n <= 1'b1;
            r_credit <= w_wspace;
            if (w_wspace == '0) begin
              r_state <= S_WAIT;
              r_gap   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          // Back off so a full UART is not hammered with reads.
          if (r_gap == GAP_LAST) begin
            r_state  <= S_POLL;
            r_cs     <= 1'b1;
            r_addr   <= 1'b1;
            r_read_n <= 1'b0;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        S_WRITE: begin
          if (w_done) begin
            r_state   <= S_IDLE;
            r_cs      <= 1'b0;
            r_write_n <= 1'b1;
            if (r_credit != '0) begin
              r_credit <= r_credit - 16'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_uart_tx_feeder.sv
// Bench for jtag_uart_tx_feeder: Avalon JTAG UART slave model with a space counter,
// byte scoreboard queue and directed plus random scenarios.
module tb_jtag_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int GAP   = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_clk = 1'b0;
  logic          reset_reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          avm_chipselect;
  logic          avm_address;
  logic          avm_read_n;
  logic [31:0]   avm_readdata = 32'h0;
  logic          avm_write_n;
  logic [31:0]   avm_writedata;
  logic          avm_waitrequest = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          busy;

  jtag_uart_tx_feeder #(.FIFO_DEPTH(DEPTH), .POLL_GAP(GAP)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .avm_chipselect(avm_chipselect), .avm_address(avm_address),
    .avm_read_n(avm_read_n), .avm_readdata(avm_readdata),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk_clk = ~clk_clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];   // accepted but not yet written bytes, in order
  logic [7:0] src_q[$];   // bytes waiting to be offered upstream
  int valid_pct = 100, wr_pct = 0, drain_pct = 0;
  int sl_space = 0, sl_cap = 64;
  int wr_stall_budget = 0, stall_obs = 0;
  int n_reads = 0, n_writes = 0, n_gap_checks = 0;
  int last_wspace = 0, wr_since_poll = 0, low_run = 0;
  bit last_read_zero = 0, prev_stall = 0;
  logic [34:0] prev_cmd = '0;

  // Upstream source: offers src_q bytes with a random valid pattern.
  initial begin : upstream_driver
    forever begin
      @(negedge clk_clk);
      if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
        in_valid = 1'b1;
        in_data  = src_q[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready === 1'b1 && src_q.size() > 0) void'(src_q.pop_front());
    end
  end

  // JTAG UART slave model plus per-cycle scoreboard of level, protocol and byte order.
  initial begin : slave_monitor
    logic [31:0] rnd;
    logic        wr;
    forever begin
      @(negedge clk_clk);
      #1;
      if (reset_reset) begin
        exp_q.delete();
        prev_stall = 0; last_read_zero = 0; low_run = 0;
        wr_since_poll = 0; last_wspace = 0;
        avm_waitrequest = 1'b0;
      end else begin
        n_tests++;
        if (fifo_level !== LW'(exp_q.size()) || exp_q.size() > DEPTH) begin
          n_fail++;
          $display("FAIL level: got %0d expected %0d at %0t", fifo_level, exp_q.size(), $time);
        end
        if (avm_chipselect === 1'b1) begin
          if (low_run > 0 && last_read_zero) begin
            n_tests++; n_gap_checks++;
            if (low_run != GAP) begin
              n_fail++;
              $display("FAIL poll_gap: got %0d idle cycles expected %0d", low_run, GAP);
            end
          end
          low_run = 0;
          n_tests++;
          if ((avm_read_n ^ avm_write_n) !== 1'b1) begin
            n_fail++;
            $display("FAIL strobe: read_n=%b write_n=%b expected exactly one low", avm_read_n, avm_write_n);
          end
          if (prev_stall) begin
            n_tests++;
            if ({avm_address, avm_read_n, avm_write_n, avm_writedata} !== prev_cmd) begin
              n_fail++;
              $display("FAIL hold: got %h expected %h while stalled", {avm_address, avm_read_n, avm_write_n, avm_writedata}, prev_cmd);
            end
          end
          wr = 1'b0;
          if (avm_write_n === 1'b0 && wr_stall_budget > 0) begin
            wr = 1'b1; wr_stall_budget--; stall_obs++;
          end else if ($urandom_range(99) < wr_pct) begin
            wr = 1'b1;
          end
          rnd = $urandom();
          avm_waitrequest = wr;
          avm_readdata    = {sl_space[15:0], rnd[15:0]};
          if (!wr) begin
            if (avm_read_n === 1'b0) begin
              n_tests++;
              if (avm_address !== 1'b1) begin
                n_fail++;
                $display("FAIL poll_addr: got %b expected 1", avm_address);
              end
              n_reads++;
              last_wspace = sl_space; wr_since_poll = 0; last_read_zero = (sl_space == 0);
            end else begin
              n_writes++;
              n_tests++;
              if (avm_address !== 1'b0 || avm_writedata[31:8] !== 24'h0) begin
                n_fail++;
                $display("FAIL write_fmt: got addr %b data %h expected addr 0 data 000000xx", avm_address, avm_writedata);
              end
              n_tests++;
              if (wr_since_poll >= last_wspace || sl_space == 0) begin
                n_fail++;
                $display("FAIL credit: got write %0d after WSPACE %0d (space now %0d) expected fewer", wr_since_poll + 1, last_wspace, sl_space);
              end
              n_tests++;
              if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL order: got byte %h expected no write", avm_writedata[7:0]);
              end else begin
                if (avm_writedata[7:0] !== exp_q[0]) begin
                  n_fail++;
                  $display("FAIL order: got byte %h expected %h", avm_writedata[7:0], exp_q[0]);
                end
                void'(exp_q.pop_front());
              end
              if (sl_space > 0) sl_space--;
              wr_since_poll++; last_read_zero = 0;
            end
          end
          prev_stall = wr;
          prev_cmd   = {avm_address, avm_read_n, avm_write_n, avm_writedata};
        end else begin
          low_run++;
          prev_stall = 0;
          avm_waitrequest = 1'b0;
          n_tests++;
          if (avm_read_n !== 1'b1 || avm_write_n !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_strobes: got read_n=%b write_n=%b expected 1/1", avm_read_n, avm_write_n);
          end
        end
        if (in_valid && in_ready === 1'b1) exp_q.push_back(in_data);
        if (sl_space < sl_cap && $urandom_range(99) < drain_pct) sl_space++;
      end
    end
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation exceeded cycle limit");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk_clk);
    reset_reset = 1'b1;
    src_q.delete();
    valid_pct = 100; wr_pct = 0; drain_pct = 0; wr_stall_budget = 0; sl_space = 0; sl_cap = 64;
    repeat (2) @(negedge clk_clk);
    reset_reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk_clk); #2;
      if (src_q.size() == 0 && exp_q.size() == 0 && avm_chipselect === 1'b0) done = 1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: got timeout after %0d cycles expected drain", name, budget);
    end else if (busy !== 1'b0 || fifo_level !== '0) begin
      n_fail++;
      $display("FAIL %s: got busy=%b level=%0d expected 0/0", name, busy, fifo_level);
    end
  endtask

  task automatic wait_reads(input int target, input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk_clk); #2;
      if (n_reads >= target) done = 1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: got %0d polls expected %0d", name, n_reads, target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_clk);
    reset_reset = 1'b1;
    @(negedge clk_clk); #2;
    n_tests++;
    if (in_ready !== 1'b0 || avm_chipselect !== 1'b0 || avm_read_n !== 1'b1 || avm_write_n !== 1'b1 ||
        avm_address !== 1'b0 || avm_writedata !== 32'h0 || fifo_level !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b cs=%b rn=%b wn=%b a=%b wd=%h lvl=%0d busy=%b expected 0 0 1 1 0 0 0 0",
               in_ready, avm_chipselect, avm_read_n, avm_write_n, avm_address, avm_writedata, fifo_level, busy);
    end
    reset_reset = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single_byte();
    int r0, w0;
    apply_reset();
    sl_space = 64; r0 = n_reads; w0 = n_writes;
    @(posedge clk_clk); src_q.push_back(8'h41);
    wait_idle(200, "single_idle");
    n_tests++;
    if (n_reads - r0 != 1 || n_writes - w0 != 1) begin
      n_fail++;
      $display("FAIL single_txn: got %0d polls %0d writes expected 1 1", n_reads - r0, n_writes - w0);
    end
    // credit 63 left: a fresh byte goes straight to a write two cycles after acceptance
    @(posedge clk_clk); src_q.push_back(8'h5a);
    @(negedge clk_clk); #2;
    @(negedge clk_clk); #2;
    n_tests++;
    if (avm_chipselect !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got cs=%b expected 0 one cycle after accept", avm_chipselect);
    end
    @(negedge clk_clk); #2;
    n_tests++;
    if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_writedata !== 32'h0000005a) begin
      n_fail++;
      $display("FAIL latency_strobe: got cs=%b wn=%b wd=%h expected 1 0 0000005a", avm_chipselect, avm_write_n, avm_writedata);
    end
    wait_idle(50, "latency_idle");
    // remaining credit 62 must carry 62 bytes without another poll
    sl_space = 200;
    @(posedge clk_clk);
    for (int i = 0; i < 62; i++) src_q.push_back(8'($urandom()));
    wait_idle(1000, "credit_idle");
    n_tests++;
    if (n_reads - r0 != 1) begin
      n_fail++;
      $display("FAIL credit_63: got %0d polls expected 1", n_reads - r0);
    end
    @(posedge clk_clk); src_q.push_back(8'hc3);
    wait_idle(200, "credit_out_idle");
    n_tests++;
    if (n_reads - r0 != 2) begin
      n_fail++;
      $display("FAIL credit_exhausted: got %0d polls expected 2", n_reads - r0);
    end
  endtask

  task automatic test_credit_repoll();
    int r0, w0, g0;
    apply_reset();
    r0 = n_reads; w0 = n_writes; g0 = n_gap_checks;
    sl_space = 3;
    @(posedge clk_clk);
    for (int i = 0; i < 5; i++) src_q.push_back(8'(16 + i));
    wait_reads(r0 + 2, 200, "repoll_zero");
    n_tests++;
    if (n_writes - w0 != 3) begin
      n_fail++;
      $display("FAIL repoll_writes: got %0d writes expected 3", n_writes - w0);
    end
    sl_space = 2;
    wait_idle(400, "repoll_idle");
    n_tests++;
    if (n_reads - r0 != 3 || n_writes - w0 != 5 || n_gap_checks - g0 != 1) begin
      n_fail++;
      $display("FAIL repoll_totals: got %0d polls %0d writes %0d gaps expected 3 5 1", n_reads - r0, n_writes - w0, n_gap_checks - g0);
    end
  endtask

  task automatic test_write_stall();
    int r0, w0, s0;
    apply_reset();
    sl_space = 10; wr_stall_budget = 7;
    r0 = n_reads; w0 = n_writes; s0 = stall_obs;
    @(posedge clk_clk); src_q.push_back(8'h7e);
    wait_idle(200, "stall_idle");
    n_tests++;
    if (stall_obs - s0 != 7 || n_writes - w0 != 1) begin
      n_fail++;
      $display("FAIL stall: got %0d stalled cycles %0d writes expected 7 1", stall_obs - s0, n_writes - w0);
    end
    // one decrement only: 9 more bytes fit without a poll
    @(posedge clk_clk);
    for (int i = 0; i < 9; i++) src_q.push_back(8'($urandom()));
    wait_idle(300, "stall_credit_idle");
    n_tests++;
    if (n_reads - r0 != 1) begin
      n_fail++;
      $display("FAIL stall_credit: got %0d polls expected 1", n_reads - r0);
    end
  endtask

  task automatic test_fifo_full();
    int w0, lmin;
    bit full = 0, started = 0;
    apply_reset();
    w0 = n_writes;
    @(posedge clk_clk);
    for (int i = 0; i < 40; i++) src_q.push_back(8'($urandom()));
    for (int i = 0; i < 200 && !full; i++) begin
      @(negedge clk_clk); #2;
      if (fifo_level === LW'(DEPTH)) full = 1;
    end
    repeat (5) @(negedge clk_clk);
    #2;
    n_tests++;
    if (fifo_level !== LW'(DEPTH) || in_ready !== 1'b0 || src_q.size() != 40 - DEPTH) begin
      n_fail++;
      $display("FAIL full: got level %0d ready %b pending %0d expected %0d 0 %0d", fifo_level, in_ready, src_q.size(), DEPTH, 40 - DEPTH);
    end
    sl_space = 16;
    for (int i = 0; i < 150 && !started; i++) begin
      @(negedge clk_clk); #2;
      if (n_writes > w0) started = 1;
    end
    lmin = DEPTH;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_clk); #2;
      if (int'(fifo_level) < lmin) lmin = int'(fifo_level);
    end
    n_tests++;
    if (!started || lmin < DEPTH - 1) begin
      n_fail++;
      $display("FAIL full_refill: got started=%0d min level %0d expected 1 %0d", started, lmin, DEPTH - 1);
    end
    sl_space = 64;
    wait_idle(600, "full_idle");
    n_tests++;
    if (n_writes - w0 != 40) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes expected 40", n_writes - w0);
    end
  endtask

  task automatic test_reset_mid_write();
    int r0, w0;
    bit seen = 0;
    apply_reset();
    sl_space = 10; wr_stall_budget = 1000;
    @(posedge clk_clk);
    for (int i = 0; i < 3; i++) src_q.push_back(8'(160 + i));
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_clk); #2;
      if (avm_chipselect === 1'b1 && avm_write_n === 1'b0) seen = 1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midreset_setup: got no stalled write expected one");
    end
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b1;
    @(negedge clk_clk); #2;
    n_tests++;
    if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || fifo_level !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got cs=%b wn=%b lvl=%0d busy=%b rdy=%b expected 0 1 0 0 0", avm_chipselect, avm_write_n, fifo_level, busy, in_ready);
    end
    src_q.delete(); wr_stall_budget = 0; sl_space = 10;
    reset_reset = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: got %b expected 1", in_ready);
    end
    r0 = n_reads; w0 = n_writes;
    @(posedge clk_clk); src_q.push_back(8'h41);
    wait_idle(200, "midreset_idle");
    n_tests++;
    if (n_reads - r0 != 1 || n_writes - w0 != 1) begin
      n_fail++;
      $display("FAIL midreset_after: got %0d polls %0d writes expected 1 1", n_reads - r0, n_writes - w0);
    end
  endtask

  task automatic test_random_stream();
    int w0;
    apply_reset();
    w0 = n_writes;
    valid_pct = 60; wr_pct = 20; drain_pct = 75; sl_cap = 64;
    sl_space = $urandom_range(64);
    @(posedge clk_clk);
    for (int i = 0; i < 10000; i++) src_q.push_back(8'($urandom()));
    wait_idle(60000, "random_idle");
    n_tests++;
    if (n_writes - w0 != 10000) begin
      n_fail++;
      $display("FAIL random_count: got %0d writes expected 10000", n_writes - w0);
    end
  endtask

  initial begin : main
    test_reset();
    test_single_byte();
    test_credit_repoll();
    test_write_stall();
    test_fifo_full();
    test_reset_mid_write();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
